wb_copy_master: RTL and testbench
=================================

WB_COPY_MASTER -- requirements
Module: wb_copy_master

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 9, word-count width (512 words = 2 KiB RAM window).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles strobe may wait for ack/err; range 1..255.
REQ-003 wb_clk  input  1  system/Wishbone clock; all logic on rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 abort_i  input  1  terminate the current copy.
REQ-007 src_adr_i  input  32  source byte address; bits [1:0] ignored.
REQ-008 dst_adr_i  input  32  destination byte address; bits [1:0] ignored.
REQ-009 len_i  input  LEN_WIDTH  number of 32-bit words to copy.
REQ-010 busy_o  output  1  high from the accepted start until the FINISH state is left.
REQ-011 done_o  output  1  one-cycle pulse at end of every accepted copy, success or failure.
REQ-012 err_code_o  output  2  00 ok, 01 bus error, 10 timeout, 11 aborted; held until next accepted start.
REQ-013 words_done_o  output  LEN_WIDTH  count of words whose write was acked.
REQ-014 wb_adr_o  output  32  Wishbone address, bits [1:0] always 0.
REQ-015 wb_dat_o  output  32  write data.
REQ-016 wb_dat_i  input  32  read data.
REQ-017 wb_we_o  output  1  write enable.
REQ-018 wb_sel_o  output  4  byte enables; 4'b1111 during every cycle of a transfer, 4'b0000 otherwise.
REQ-019 wb_stb_o / wb_cyc_o  output  1 each  strobe and cycle; always equal.
REQ-020 wb_ack_i / wb_err_i  input  1 each  responder acknowledge and error.

Function
REQ-021 SHALL be a classic single-transfer Wishbone initiator; all wb_* outputs registered.
REQ-022 States SHALL be IDLE, READ, RGAP, WRITE, WGAP, FINISH.
REQ-023 IDLE + start_i: latch src, dst, len; clear idx, words_done_o and err_code_o; go READ, or go FINISH if len_i==0 (no bus activity).
REQ-024 start_i outside IDLE SHALL be ignored.
REQ-025 READ: cyc=stb=1, we=0, adr = src + 4*idx modulo 2^32.
REQ-026 On ack sampled in READ: latch wb_dat_i into the data register; drop stb/cyc at the same edge; go RGAP.
REQ-027 RGAP (one cycle, stb low): go WRITE.
REQ-028 WRITE: cyc=stb=1, we=1, adr = dst + 4*idx modulo 2^32, dat = data register.
REQ-029 On ack sampled in WRITE: increment words_done_o; drop stb/cyc; go WGAP.
REQ-030 WGAP: increment idx; go FINISH if the new idx equals len, else go READ.
REQ-031 Strobe SHALL deassert the edge after ack is sampled, so a responder acking with a registered cyc&stb&~ack never double-acks.
REQ-032 With a 1-cycle-latency responder, each word SHALL take exactly 6 wb_clk cycles.
REQ-033 Timeout counter SHALL reset on entry to READ/WRITE and count each strobed cycle without ack/err; reaching TIMEOUT_CYCLES sets err_code_o=10, drops stb/cyc, goes FINISH.
REQ-034 wb_err_i sampled in READ/WRITE SHALL set err_code_o=01, drop stb/cyc, go FINISH.
REQ-035 Simultaneous wb_err_i and wb_ack_i: the error wins and the word is not counted.
REQ-036 abort_i in READ/RGAP/WRITE/WGAP SHALL set err_code_o=11, drop stb/cyc at the next edge, and go FINISH.
REQ-037 abort_i in IDLE/FINISH SHALL have no effect.
REQ-038 abort_i with an ack in the same WRITE cycle: the word is counted, then abort is taken.
REQ-039 Abort priority over timeout and bus error.
REQ-040 FINISH: done_o=1 for one cycle; busy_o low from the next cycle; return to IDLE.
REQ-041 The block SHALL accept a new start in the cycle after FINISH.

Reset
REQ-042 rstn_i low SHALL asynchronously force IDLE and clear all outputs: busy_o, done_o, err_code_o, words_done_o, wb_stb_o, wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o.
REQ-043 Reset mid-transfer SHALL drop cyc/stb immediately with no done_o pulse; internal idx/data cleared.

Verification
REQ-044 src=0x800, dst=0xA00, len=3, 1-cycle ack responder with RAM model -> three words copied, reads at 0x800/0x804/0x808 then writes at 0xA00/0xA04/0xA08 interleaved, done_o at cycle 18 after start, err_code_o=00, words_done_o=3.
REQ-045 len=0 -> no stb; done_o the cycle after FINISH entry; err_code_o=00, words_done_o=0.
REQ-046 Responder never acks, TIMEOUT_CYCLES=8 -> stb held exactly 8 cycles, then dropped; err_code_o=10; done_o pulse; words_done_o=0.
REQ-047 wb_err_i together with ack on the second write of len=4 -> err_code_o=01, words_done_o=1, no further strobes.
REQ-048 abort_i asserted in the cycle of the third write ack, len=5 -> words_done_o=3, err_code_o=11, stb low next edge.
REQ-049 src=0xFFFFFFFC, len=2 -> second read address 0x00000000 (wrap); start_i pulsed while busy is ignored.

Source files
------------

// File: rtl/wb_copy_master.sv
// Wishbone classic single-transfer copy engine: reads a word from src, writes it to dst,
// repeats len times; reports ok / bus error / timeout / abort and the count of acked writes.
module wb_copy_master #(
  parameter int LEN_WIDTH      = 9,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 wb_clk,
  input  logic                 rstn_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [31:0]          src_adr_i,
  input  logic [31:0]          dst_adr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           err_code_o,
  output logic [LEN_WIDTH-1:0] words_done_o,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  input  logic [31:0]          wb_dat_i,
  output logic                 wb_we_o,
  output logic [3:0]           wb_sel_o,
  output logic                 wb_stb_o,
  output logic                 wb_cyc_o,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i
);

  typedef enum logic [2:0] {IDLE, READ, RGAP, WRITE, WGAP, FINISH} state_t;

  localparam logic [1:0] E_OK = 2'b00, E_BUS = 2'b01, E_TMO = 2'b10, E_ABT = 2'b11;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [31:0]          src, dst, data;
  logic [LEN_WIDTH-1:0] len, idx, idx_nxt;
  logic [7:0]           tmo_cnt;

  assign idx_nxt = idx + 1'b1;

  // base + 4*i, wrapping modulo 2^32, with the byte-lane bits forced to zero
  function automatic logic [31:0] word_adr(input logic [31:0] base, input logic [LEN_WIDTH-1:0] i);
    logic [31:0] sum;
    sum = base + {{(30-LEN_WIDTH){1'b0}}, i, 2'b00};
    return sum & 32'hFFFF_FFFC;
  endfunction

  always_ff @(posedge wb_clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      src          <= '0;
      dst          <= '0;
      data         <= '0;
      len          <= '0;
      idx          <= '0;
      tmo_cnt      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_code_o   <= E_OK;
      words_done_o <= '0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_we_o      <= 1'b0;
      wb_sel_o     <= 4'h0;
      wb_stb_o     <= 1'b0;
      wb_cyc_o     <= 1'b0;
    end else begin
      // Bus is released every edge unless a branch below keeps or starts a strobe.
      done_o   <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_sel_o <= 4'h0;
      wb_we_o  <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          src          <= src_adr_i;
          dst          <= dst_adr_i;
          len          <= len_i;
          idx          <= '0;
          words_done_o <= '0;
          err_code_o   <= E_OK;
          busy_o       <= 1'b1;
          tmo_cnt      <= '0;
          if (len_i == '0) begin
            state  <= FINISH;
            done_o <= 1'b1;
          end else begin
            state    <= READ;
            wb_adr_o <= word_adr(src_adr_i, '0);
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            wb_sel_o <= 4'hF;
          end
        end
        READ, WRITE: begin
          if (state == WRITE && wb_ack_i && !wb_err_i)
            words_done_o <= words_done_o + 1'b1;
          if (abort_i) begin
            err_code_o <= E_ABT;
            state      <= FINISH;
            done_o     <= 1'b1;
          end else if (wb_err_i) begin
            err_code_o <= E_BUS;
            state      <= FINISH;
            done_o     <= 1'b1;
          end else if (wb_ack_i) begin
            if (state == READ) begin
              data  <= wb_dat_i;
              state <= RGAP;
            end else begin
              state <= WGAP;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            err_code_o <= E_TMO;
            state      <= FINISH;
            done_o     <= 1'b1;
          end else begin
            tmo_cnt  <= tmo_cnt + 1'b1;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            wb_sel_o <= 4'hF;
            wb_we_o  <= (state == WRITE);
          end
        end
        RGAP: if (abort_i) begin
          err_code_o <= E_ABT;
          state      <= FINISH;
          done_o     <= 1'b1;
        end else begin
          state    <= WRITE;
          tmo_cnt  <= '0;
          wb_adr_o <= word_adr(dst, idx);
          wb_dat_o <= data;
          wb_stb_o <= 1'b1;
          wb_cyc_o <= 1'b1;
          wb_sel_o <= 4'hF;
          wb_we_o  <= 1'b1;
        end
        WGAP: begin
          idx <= idx_nxt;
          if (abort_i) begin
            err_code_o <= E_ABT;
            state      <= FINISH;
            done_o     <= 1'b1;
          end else if (idx_nxt == len) begin
            state  <= FINISH;
            done_o <= 1'b1;
          end else begin
            state    <= READ;
            tmo_cnt  <= '0;
            wb_adr_o <= word_adr(src, idx_nxt);
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            wb_sel_o <= 4'hF;
          end
        end
        FINISH: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master: 1-cycle-latency RAM responder with
// optional never-ack and error-on-Nth-write modes; logs every bus transfer.
module tb_wb_copy_master;

  logic        wb_clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0, abort_i = 1'b0;
  logic [31:0] src_adr_i = '0, dst_adr_i = '0;
  logic [8:0]  len_i = '0;
  logic        busy_o, done_o;
  logic [1:0]  err_code_o;
  logic [8:0]  words_done_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;

  always #5 wb_clk = ~wb_clk;

  wb_copy_master #(.LEN_WIDTH(9), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk(wb_clk), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
    .src_adr_i(src_adr_i), .dst_adr_i(dst_adr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_code_o(err_code_o), .words_done_o(words_done_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i));

  logic [31:0] mem [0:1023];
  logic        noack = 1'b0;
  int          err_at = 0;
  int          wr_n, log_n, stb_cnt;
  logic [31:0] log_adr [0:15];
  logic [31:0] log_dat [0:15];
  logic        log_we  [0:15];
  int          n_tests = 0, n_fail = 0;

  // Responder: registered ack = cyc&stb&~ack; bookkeeping restarts on each accepted start.
  always @(posedge wb_clk) begin
    if (wb_stb_o) stb_cnt <= stb_cnt + 1;
    if (start_i && !busy_o) begin
      wr_n <= 0; log_n <= 0; stb_cnt <= 0;
    end
    if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && !noack) begin
      if (log_n < 16) begin
        log_adr[log_n] <= wb_adr_o;
        log_dat[log_n] <= wb_dat_o;
        log_we[log_n]  <= wb_we_o;
        log_n <= log_n + 1;
      end
      wb_ack_i <= 1'b1;
      if (wb_we_o) begin
        wr_n <= wr_n + 1;
        wb_err_i <= (wr_n + 1 == err_at);
      end else begin
        wb_dat_i <= mem[wb_adr_o[11:2]];
      end
    end else begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse start, then count edges after the start edge until done_o is seen.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [8:0] l,
                          input int abort_at, input int poke_at, output int lat);
    @(posedge wb_clk); #1;
    src_adr_i = s; dst_adr_i = d; len_i = l; start_i = 1'b1;
    @(posedge wb_clk); #1;
    start_i = 1'b0;
    lat = 0;
    while (!done_o && lat < 400) begin
      @(posedge wb_clk); #1;
      lat++;
      abort_i = (lat == abort_at);
      start_i = (lat == poke_at);
      if (lat == poke_at) begin
        src_adr_i = 32'h100; len_i = 9'd7;
      end
    end
    abort_i = 1'b0; start_i = 1'b0;
    if (!done_o) chk("done_never_seen", 32'(done_o), 32'd1);
  endtask

  int lat;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | i;
    mem[10'h200] = 32'h1111_AAAA;
    mem[10'h201] = 32'h2222_BBBB;
    mem[10'h202] = 32'h3333_CCCC;
    mem[10'h3FF] = 32'hCAFE_F00D;
    mem[10'h000] = 32'h0BAD_BEEF;

    #12;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_code_o), 0);
    chk("rst_words", 32'(words_done_o), 0);
    chk("rst_bus", {wb_stb_o, wb_cyc_o, wb_we_o, wb_sel_o}, 0);
    chk("rst_adr_dat", wb_adr_o | wb_dat_o, 0);
    rstn_i = 1'b1;

    // basic 3-word copy
    run_copy(32'h800, 32'hA00, 9'd3, -1, -1, lat);
    chk("copy3_lat", lat, 18);
    chk("copy3_err", 32'(err_code_o), 0);
    chk("copy3_words", 32'(words_done_o), 3);
    chk("copy3_busy_in_finish", 32'(busy_o), 1);
    chk("copy3_nlog", log_n, 6);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("copy3_radr%0d", i), log_adr[2*i], 32'h800 + 4*i);
      chk($sformatf("copy3_rwe%0d", i), 32'(log_we[2*i]), 0);
      chk($sformatf("copy3_wadr%0d", i), log_adr[2*i+1], 32'hA00 + 4*i);
      chk($sformatf("copy3_wwe%0d", i), 32'(log_we[2*i+1]), 1);
    end
    chk("copy3_wdat0", log_dat[1], 32'h1111_AAAA);
    chk("copy3_wdat1", log_dat[3], 32'h2222_BBBB);
    chk("copy3_wdat2", log_dat[5], 32'h3333_CCCC);

    // len=0, started in the cycle right after FINISH
    run_copy(32'h800, 32'hA00, 9'd0, -1, -1, lat);
    chk("len0_lat", lat, 0);
    chk("len0_err", 32'(err_code_o), 0);
    chk("len0_words", 32'(words_done_o), 0);
    chk("len0_nostb", stb_cnt, 0);
    @(posedge wb_clk); #1;
    chk("len0_busy_after", 32'(busy_o), 0);
    chk("len0_done_1cyc", 32'(done_o), 0);

    // timeout: responder silent
    noack = 1'b1;
    run_copy(32'h800, 32'hA00, 9'd1, -1, -1, lat);
    chk("tmo_lat", lat, 8);
    chk("tmo_stb_cycles", stb_cnt, 8);
    chk("tmo_stb_low", 32'(wb_stb_o | wb_cyc_o), 0);
    chk("tmo_err", 32'(err_code_o), 2);
    chk("tmo_words", 32'(words_done_o), 0);
    noack = 1'b0;

    // bus error together with ack on second write
    err_at = 2;
    run_copy(32'h800, 32'hA00, 9'd4, -1, -1, lat);
    chk("berr_lat", lat, 11);
    chk("berr_err", 32'(err_code_o), 1);
    chk("berr_words", 32'(words_done_o), 1);
    repeat (4) @(posedge wb_clk);
    #1;
    chk("berr_no_more_stb", log_n, 4);
    err_at = 0;

    // abort in the cycle of the third write ack
    run_copy(32'h800, 32'hA00, 9'd5, 16, -1, lat);
    chk("abort_lat", lat, 17);
    chk("abort_stb_low", 32'(wb_stb_o), 0);
    chk("abort_err", 32'(err_code_o), 3);
    chk("abort_words", 32'(words_done_o), 3);
    chk("abort_nlog", log_n, 6);

    // address wrap, and a start pulse while busy that must be ignored
    run_copy(32'hFFFF_FFFC, 32'h900, 9'd2, -1, 3, lat);
    chk("wrap_lat", lat, 12);
    chk("wrap_err", 32'(err_code_o), 0);
    chk("wrap_words", 32'(words_done_o), 2);
    chk("wrap_radr0", log_adr[0], 32'hFFFF_FFFC);
    chk("wrap_radr1", log_adr[2], 32'h0000_0000);
    chk("wrap_wadr1", log_adr[3], 32'h904);
    chk("wrap_wdat1", log_dat[3], 32'h0BAD_BEEF);
    repeat (3) @(posedge wb_clk);
    #1;
    chk("wrap_idle_after", 32'(busy_o), 0);

    // reset in the middle of a transfer
    @(posedge wb_clk); #1;
    src_adr_i = 32'h800; dst_adr_i = 32'hA00; len_i = 9'd3; start_i = 1'b1;
    @(posedge wb_clk); #1;
    start_i = 1'b0;
    @(posedge wb_clk); #2;
    rstn_i = 1'b0;
    #1;
    chk("midrst_bus", {wb_stb_o, wb_cyc_o, wb_sel_o}, 0);
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_done", 32'(done_o), 0);
    #20;
    rstn_i = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
